fpu_lane_merge: RTL and testbench

Parametrised N-lane, N-port retire/flag merger for the split FPU datapath, successor to the fixed two-half (high/low) merge. Per issue port, it ORs the retire words of all lane slices. It carries each issued op's lane selector through an LAT-stage delay line and picks that lane's compare flags when the op reaches writeback. It also accumulates exception flags into a sticky register and latches lane-collision errors. It sits between the per-lane FPU slices and the FUS/retire buses.

---
 rtl/fpu_merge_pkg.sv | 28 ++
 rtl/fpu_op_delay.sv | 49 ++++
 rtl/fpu_lane_merge.sv | 140 ++++++++++++++
 tb/tb_fpu_lane_merge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_merge_pkg.sv
// +----------------------------------------------------------------------------+
// | fpu_merge_pkg                                                              |
// | Shared defaults and delay-line entry type for the FPU lane merger.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpu_merge_pkg;

  localparam int LAT_DEF    = 4;
  localparam int RET_W_DEF  = 14;
  localparam int FLG_W_DEF  = 6;

  // Widest lane index the delay entry can carry; narrower indices are zero-extended.
  localparam int LANE_W_MAX = 4;

  typedef struct packed {
    logic                  vld;
    logic [LANE_W_MAX-1:0] lane;
  } delay_entry_t;

  function automatic int lane_w(input int n_lane);
    return (n_lane > 1) ? $clog2(n_lane) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_op_delay.sv
// +----------------------------------------------------------------------------+
// | fpu_op_delay                                                               |
// | One issue port's LAT-stage {vld, lane} shift register with flush and clamp.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_op_delay
  import fpu_merge_pkg::*;
#(
  parameter int LAT    = LAT_DEF,
  parameter int N_LANE = 2,
  parameter int LW     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [LW-1:0] in_lane,
  output delay_entry_t  out_ent
);

  delay_entry_t [LAT-1:0] stage_q;
  delay_entry_t [LAT-1:0] stage_d;

  // Out-of-range lane indices are folded onto lane 0 so the flag mux never misses.
  always_comb begin
    stage_d          = '0;
    stage_d[0].vld   = in_vld & ~flush;
    stage_d[0].lane  = (int'(in_lane) < N_LANE) ? LANE_W_MAX'(in_lane) : '0;
    for (int k = 1; k < LAT; k++) begin
      stage_d[k].vld  = stage_q[k-1].vld & ~flush;
      stage_d[k].lane = stage_q[k-1].lane;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_ent = stage_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/fpu_lane_merge.sv
// +----------------------------------------------------------------------------+
// | fpu_lane_merge                                                             |
// | N-lane/N-port retire OR-merge, delayed lane flag select, sticky flags and  |
// | lane-collision latch. Sticky register built only with FPU_MERGE_STICKY_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_lane_merge
  import fpu_merge_pkg::*;
#(
  parameter int N_PORT = 3,
  parameter int N_LANE = 2,
  parameter int LAT    = LAT_DEF,
  parameter int RET_W  = RET_W_DEF,
  parameter int FLG_W  = FLG_W_DEF,
  parameter int LW     = lane_w(N_LANE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORT-1:0]               iss_vld,
  input  logic [N_PORT*LW-1:0]            iss_lane,
  input  logic                            flush,
  input  logic [N_LANE*N_PORT*RET_W-1:0]  lane_ret,
  input  logic [N_LANE*N_PORT-1:0]        lane_ret_en,
  input  logic [N_LANE*N_PORT*FLG_W-1:0]  lane_flg,
  output logic [N_PORT*RET_W-1:0]         ret,
  output logic [N_PORT-1:0]               ret_en,
  output logic [N_PORT*FLG_W-1:0]         flg,
  output logic [N_PORT-1:0]               flg_vld,
  output logic [FLG_W-1:0]                sticky,
  input  logic                            sticky_clr,
  output logic                            err_multi
);

  delay_entry_t [N_PORT-1:0] ent;
  logic                      multi;
  logic                      seen;
  logic                      err_multi_q;
  logic                      err_multi_d;

  always_comb begin
    ret    = '0;
    ret_en = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int l = 0; l < N_LANE; l++) begin
        ret[p*RET_W +: RET_W] = ret[p*RET_W +: RET_W] | lane_ret[(l*N_PORT+p)*RET_W +: RET_W];
        ret_en[p]             = ret_en[p] | lane_ret_en[l*N_PORT+p];
      end
    end
  end

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    fpu_op_delay #(
      .LAT    (LAT),
      .N_LANE (N_LANE),
      .LW     (LW)
    ) u_delay (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_vld  (iss_vld[p]),
      .in_lane (iss_lane[p*LW +: LW]),
      .out_ent (ent[p])
    );
  end

  // Invalid slots return zeros rather than falling back to the low lane.
  always_comb begin
    flg     = '0;
    flg_vld = '0;
    for (int p = 0; p < N_PORT; p++) begin
      flg_vld[p] = ent[p].vld;
      for (int l = 0; l < N_LANE; l++) begin
        if (ent[p].vld && (ent[p].lane == LANE_W_MAX'(l))) begin
          flg[p*FLG_W +: FLG_W] = lane_flg[(l*N_PORT+p)*FLG_W +: FLG_W];
        end
      end
    end
  end

  always_comb begin
    multi = 1'b0;
    seen  = 1'b0;
    for (int p = 0; p < N_PORT; p++) begin
      seen = 1'b0;
      for (int l = 0; l < N_LANE; l++) begin
        if (lane_ret_en[l*N_PORT+p]) begin
          multi = multi | seen;
          seen  = 1'b1;
        end
      end
    end
    err_multi_d = err_multi_q | multi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_multi_q <= 1'b0;
    end else begin
      err_multi_q <= err_multi_d;
    end
  end

  assign err_multi = err_multi_q;

`ifdef FPU_MERGE_STICKY_EN
  logic [FLG_W-1:0] sticky_q;
  logic [FLG_W-1:0] sticky_d;
  logic [FLG_W-1:0] flg_new;

  // Clear is applied before the OR so flags arriving in the clear cycle survive.
  always_comb begin
    flg_new = '0;
    for (int p = 0; p < N_PORT; p++) begin
      if (flg_vld[p]) begin
        flg_new = flg_new | flg[p*FLG_W +: FLG_W];
      end
    end
    sticky_d = (sticky_clr ? '0 : sticky_q) | flg_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_lane_merge.sv
// +----------------------------------------------------------------------------+
// | tb_fpu_lane_merge                                                          |
// | Randomised self-checking bench for fpu_lane_merge with a cycle-history     |
// | reference model.                                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fpu_lane_merge;

  localparam int N_PORT = 3;
  localparam int N_LANE = 2;
  localparam int LAT    = 4;
  localparam int RET_W  = 14;
  localparam int FLG_W  = 6;
  localparam int LW     = 1;
  localparam int DEPTH  = 1024;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [N_PORT-1:0]              iss_vld;
  logic [N_PORT*LW-1:0]           iss_lane;
  logic                           flush;
  logic [N_LANE*N_PORT*RET_W-1:0] lane_ret;
  logic [N_LANE*N_PORT-1:0]       lane_ret_en;
  logic [N_LANE*N_PORT*FLG_W-1:0] lane_flg;
  logic [N_PORT*RET_W-1:0]        ret;
  logic [N_PORT-1:0]              ret_en;
  logic [N_PORT*FLG_W-1:0]        flg;
  logic [N_PORT-1:0]              flg_vld;
  logic [FLG_W-1:0]               sticky;
  logic                           sticky_clr;
  logic                           err_multi;

  always #5 clk = ~clk;

  fpu_lane_merge #(
    .N_PORT (N_PORT),
    .N_LANE (N_LANE),
    .LAT    (LAT),
    .RET_W  (RET_W),
    .FLG_W  (FLG_W),
    .LW     (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iss_vld     (iss_vld),
    .iss_lane    (iss_lane),
    .flush       (flush),
    .lane_ret    (lane_ret),
    .lane_ret_en (lane_ret_en),
    .lane_flg    (lane_flg),
    .ret         (ret),
    .ret_en      (ret_en),
    .flg         (flg),
    .flg_vld     (flg_vld),
    .sticky      (sticky),
    .sticky_clr  (sticky_clr),
    .err_multi   (err_multi)
  );

  // Reference model: history of what was issued/flushed in each numbered cycle.
  bit               iv [DEPTH][N_PORT];
  int               il [DEPTH][N_PORT];
  bit               fl [DEPTH];
  int               cyc;
  int               start_cyc;
  logic [FLG_W-1:0] exp_sticky;
  bit               exp_err;
  int               n_cmp;
  int               n_bad;

  function automatic bit exp_vld(input int p);
    int s;
    s = cyc - LAT;
    if (s < start_cyc) return 1'b0;
    if (!iv[s][p]) return 1'b0;
    for (int k = s; k < cyc; k++) begin
      if (fl[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [FLG_W-1:0] exp_flg(input int p);
    int ln;
    if (!exp_vld(p)) return '0;
    ln = il[cyc-LAT][p];
    if (ln >= N_LANE) ln = 0;
    return lane_flg[(ln*N_PORT+p)*FLG_W +: FLG_W];
  endfunction

  function automatic logic [RET_W-1:0] exp_ret(input int p);
    logic [RET_W-1:0] w;
    w = '0;
    for (int l = 0; l < N_LANE; l++) w = w | lane_ret[(l*N_PORT+p)*RET_W +: RET_W];
    return w;
  endfunction

  function automatic logic exp_ret_en(input int p);
    logic e;
    e = 1'b0;
    for (int l = 0; l < N_LANE; l++) e = e | lane_ret_en[l*N_PORT+p];
    return e;
  endfunction

  task automatic rand_flg();
    for (int i = 0; i < N_LANE*N_PORT*FLG_W; i++) lane_flg[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_ret();
    for (int i = 0; i < N_LANE*N_PORT*RET_W; i++) lane_ret[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic begin_cycle(input logic [N_PORT-1:0] v, input logic [N_PORT*LW-1:0] ln,
                             input logic f, input logic c);
    @(negedge clk);
    if (cyc >= DEPTH) begin
      $display("FAIL model_depth: cycle %0d exceeds history %0d", cyc, DEPTH);
      $fatal(1);
    end
    iss_vld    = v;
    iss_lane   = ln;
    flush      = f;
    sticky_clr = c;
    fl[cyc]    = f;
    for (int p = 0; p < N_PORT; p++) begin
      iv[cyc][p] = v[p];
      il[cyc][p] = int'(ln[p*LW +: LW]);
    end
  endtask

  task automatic end_cycle();
    int cnt;
`ifdef FPU_MERGE_STICKY_EN
    logic [FLG_W-1:0] nw;
    nw = '0;
    for (int p = 0; p < N_PORT; p++) nw = nw | exp_flg(p);
    exp_sticky = (sticky_clr ? '0 : exp_sticky) | nw;
`endif
    for (int p = 0; p < N_PORT; p++) begin
      cnt = 0;
      for (int l = 0; l < N_LANE; l++) cnt += int'(lane_ret_en[l*N_PORT+p]);
      if (cnt >= 2) exp_err = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int r = 0; r < n; r++) begin
      begin_cycle('0, '0, 1'b0, 1'b0);
      lane_ret_en = '0;
      rand_flg();
      #1;
      end_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; iss_vld = '0; iss_lane = '0; flush = 1'b0; sticky_clr = 1'b0;
    lane_ret = '0; lane_ret_en = '0; lane_flg = '0;
    cyc = 0; start_cyc = 0; exp_sticky = '0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (flg_vld !== '0) begin n_bad++; $display("FAIL reset_flg_vld: got %b want 0", flg_vld); end
    n_cmp++; if (flg !== '0) begin n_bad++; $display("FAIL reset_flg: got %h want 0", flg); end
    n_cmp++; if (sticky !== '0) begin n_bad++; $display("FAIL reset_sticky: got %h want 0", sticky); end
    n_cmp++; if (err_multi !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_multi); end
    rand_ret();
    lane_ret_en = 6'b000_111;
    #1;
    for (int p = 0; p < N_PORT; p++) begin
      n_cmp++;
      if (ret[p*RET_W +: RET_W] !== exp_ret(p)) begin
        n_bad++; $display("FAIL reset_ret p%0d: got %h want %h", p, ret[p*RET_W +: RET_W], exp_ret(p));
      end
    end
    n_cmp++; if (ret_en !== 3'b111) begin n_bad++; $display("FAIL reset_ret_en: got %b want 111", ret_en); end
    lane_ret_en = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    idle(LAT);
    for (int r = 0; r <= LAT + 1; r++) begin
      begin_cycle((r == 0) ? 3'b001 : 3'b000, (r == 0) ? 3'b001 : 3'b000, 1'b0, 1'b0);
      rand_flg();
      if (r == LAT) begin
        lane_flg[(1*N_PORT+0)*FLG_W +: FLG_W] = 6'h2A;
        lane_flg[(0*N_PORT+0)*FLG_W +: FLG_W] = 6'h15;
      end
      #1;
      if (r == LAT) begin
        n_cmp++; if (flg[FLG_W-1:0] !== 6'h2A) begin n_bad++; $display("FAIL directed_flg: got %h want 2a", flg[FLG_W-1:0]); end
        n_cmp++; if (flg_vld[0] !== 1'b1) begin n_bad++; $display("FAIL directed_vld r=%0d: got %b want 1", r, flg_vld[0]); end
      end else begin
        n_cmp++; if (flg_vld[0] !== 1'b0) begin n_bad++; $display("FAIL directed_vld r=%0d: got %b want 0", r, flg_vld[0]); end
        n_cmp++; if (flg[FLG_W-1:0] !== '0) begin n_bad++; $display("FAIL directed_flg_zero r=%0d: got %h want 0", r, flg[FLG_W-1:0]); end
      end
      end_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 20; r++) begin
      begin_cycle(3'b111, (r % 2 == 1) ? 3'b010 : 3'b101, 1'b0, 1'b0);
      rand_flg();
      #1;
      for (int p = 0; p < N_PORT; p++) begin
        n_cmp++;
        if (flg_vld[p] !== exp_vld(p) || flg[p*FLG_W +: FLG_W] !== exp_flg(p)) begin
          n_bad++; $display("FAIL b2b r=%0d p%0d: got vld=%b flg=%h want vld=%b flg=%h",
                            r, p, flg_vld[p], flg[p*FLG_W +: FLG_W], exp_vld(p), exp_flg(p));
        end
      end
      if (r >= LAT) begin
        n_cmp++; if (flg_vld !== 3'b111) begin n_bad++; $display("FAIL b2b_continuous r=%0d: got %b want 111", r, flg_vld); end
      end
      end_cycle();
    end
  endtask

  task automatic test_flush();
    idle(LAT);
    for (int r = 0; r <= 8; r++) begin
      begin_cycle((r == 0 || r == 2 || r == 3) ? 3'b010 : 3'b000, 3'($urandom), r == 2, 1'b0);
      rand_flg();
      #1;
      n_cmp++;
      if (flg_vld[1] !== exp_vld(1) || flg[FLG_W +: FLG_W] !== exp_flg(1)) begin
        n_bad++; $display("FAIL flush_model r=%0d: got vld=%b flg=%h want vld=%b flg=%h",
                          r, flg_vld[1], flg[FLG_W +: FLG_W], exp_vld(1), exp_flg(1));
      end
      if (r == 4 || r == 6) begin
        n_cmp++; if (flg_vld[1] !== 1'b0) begin n_bad++; $display("FAIL flush_kill r=%0d: got %b want 0", r, flg_vld[1]); end
      end
      if (r == 7) begin
        n_cmp++; if (flg_vld[1] !== 1'b1) begin n_bad++; $display("FAIL flush_after r=%0d: got %b want 1", r, flg_vld[1]); end
      end
      end_cycle();
    end
  endtask

  task automatic test_sticky();
    logic [FLG_W-1:0] want05;
    logic [FLG_W-1:0] want08;
`ifdef FPU_MERGE_STICKY_EN
    want05 = 6'h05;
    want08 = 6'h08;
`else
    want05 = 6'h00;
    want08 = 6'h00;
`endif
    idle(LAT);
    begin_cycle('0, '0, 1'b0, 1'b1);
    lane_flg = '0;
    #1;
    end_cycle();
    for (int r = 0; r <= LAT + 3; r++) begin
      begin_cycle((r <= 2) ? 3'b001 : 3'b000, 3'b000, 1'b0, r == LAT + 2);
      lane_flg = '0;
      if (r == LAT)     lane_flg[FLG_W-1:0] = 6'h01;
      if (r == LAT + 1) lane_flg[FLG_W-1:0] = 6'h04;
      if (r == LAT + 2) lane_flg[FLG_W-1:0] = 6'h08;
      #1;
      n_cmp++; if (sticky !== exp_sticky) begin n_bad++; $display("FAIL sticky_model r=%0d: got %h want %h", r, sticky, exp_sticky); end
      if (r == 0) begin
        n_cmp++; if (sticky !== '0) begin n_bad++; $display("FAIL sticky_cleared: got %h want 0", sticky); end
      end
      if (r == LAT + 2) begin
        n_cmp++; if (sticky !== want05) begin n_bad++; $display("FAIL sticky_accum: got %h want %h", sticky, want05); end
      end
      if (r == LAT + 3) begin
        n_cmp++; if (sticky !== want08) begin n_bad++; $display("FAIL sticky_clr_set: got %h want %h", sticky, want08); end
      end
      end_cycle();
    end
  endtask

  task automatic test_collision();
    logic [RET_W-1:0] want;
    begin_cycle('0, '0, 1'b0, 1'b0);
    rand_flg();
    rand_ret();
    lane_ret_en = '0;
    lane_ret_en[0*N_PORT+2] = 1'b1;
    lane_ret_en[1*N_PORT+2] = 1'b1;
    want = lane_ret[(0*N_PORT+2)*RET_W +: RET_W] | lane_ret[(1*N_PORT+2)*RET_W +: RET_W];
    #1;
    n_cmp++; if (err_multi !== 1'b0) begin n_bad++; $display("FAIL coll_before: got %b want 0", err_multi); end
    n_cmp++; if (ret_en[2] !== 1'b1) begin n_bad++; $display("FAIL coll_ret_en: got %b want 1", ret_en[2]); end
    n_cmp++; if (ret[2*RET_W +: RET_W] !== want) begin n_bad++; $display("FAIL coll_ret: got %h want %h", ret[2*RET_W +: RET_W], want); end
    end_cycle();
    for (int r = 0; r < 3; r++) begin
      begin_cycle('0, '0, 1'b0, 1'b0);
      lane_ret_en = '0;
      rand_flg();
      #1;
      n_cmp++; if (err_multi !== 1'b1) begin n_bad++; $display("FAIL coll_hold r=%0d: got %b want 1", r, err_multi); end
      n_cmp++; if (ret_en !== 3'b000) begin n_bad++; $display("FAIL coll_ret_en_idle r=%0d: got %b want 000", r, ret_en); end
      end_cycle();
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 80; r++) begin
      begin_cycle(3'($urandom), 3'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      rand_flg();
      rand_ret();
      lane_ret_en = 6'($urandom);
      #1;
      for (int p = 0; p < N_PORT; p++) begin
        n_cmp++;
        if (flg_vld[p] !== exp_vld(p) || flg[p*FLG_W +: FLG_W] !== exp_flg(p)) begin
          n_bad++; $display("FAIL rand_flg r=%0d p%0d: got vld=%b flg=%h want vld=%b flg=%h",
                            r, p, flg_vld[p], flg[p*FLG_W +: FLG_W], exp_vld(p), exp_flg(p));
        end
        n_cmp++;
        if (ret[p*RET_W +: RET_W] !== exp_ret(p) || ret_en[p] !== exp_ret_en(p)) begin
          n_bad++; $display("FAIL rand_ret r=%0d p%0d: got %h/%b want %h/%b",
                            r, p, ret[p*RET_W +: RET_W], ret_en[p], exp_ret(p), exp_ret_en(p));
        end
      end
      n_cmp++; if (sticky !== exp_sticky) begin n_bad++; $display("FAIL rand_sticky r=%0d: got %h want %h", r, sticky, exp_sticky); end
      n_cmp++; if (err_multi !== exp_err) begin n_bad++; $display("FAIL rand_err r=%0d: got %b want %b", r, err_multi, exp_err); end
      end_cycle();
    end
  endtask

  task automatic test_reset_mid();
    lane_ret_en = '0;
    for (int r = 0; r < LAT; r++) begin
      begin_cycle(3'b111, 3'($urandom), 1'b0, 1'b0);
      lane_flg = '1;
      #1;
      end_cycle();
    end
    begin_cycle('0, '0, 1'b0, 1'b0);
    lane_flg = '1;
    #1;
    n_cmp++; if (flg_vld !== 3'b111) begin n_bad++; $display("FAIL rstmid_full: got %b want 111", flg_vld); end
    #1;
    rst     = 1'b0;
    iss_vld = '0;
    #1;
    n_cmp++; if (flg_vld !== '0) begin n_bad++; $display("FAIL rstmid_async_vld: got %b want 0", flg_vld); end
    n_cmp++; if (flg !== '0) begin n_bad++; $display("FAIL rstmid_async_flg: got %h want 0", flg); end
    n_cmp++; if (sticky !== '0) begin n_bad++; $display("FAIL rstmid_async_sticky: got %h want 0", sticky); end
    n_cmp++; if (err_multi !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_err: got %b want 0", err_multi); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc++;
    start_cyc  = cyc;
    exp_sticky = '0;
    exp_err    = 1'b0;
    for (int r = 0; r < LAT + 3; r++) begin
      begin_cycle('0, '0, 1'b0, 1'b0);
      rand_flg();
      #1;
      n_cmp++; if (flg_vld !== '0) begin n_bad++; $display("FAIL rstmid_after r=%0d: got %b want 0", r, flg_vld); end
      end_cycle();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_sticky();
    test_collision();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
